// File: rtl/dev_to_maxil_pipe.sv
// Pipelined Ibex device-port to AXI-Lite master bridge with a single issue slot,
// in-order responses, 32/64-bit lane steering and a read-poll throttle.
`timescale 1ns/1ps
module dev_to_maxil_pipe #(
  parameter int ADDR_WIDTH      = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int POLL_GAP        = 8,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1),
  localparam int SW = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      data_req_i,
  input  logic [31:0]               data_addr_i,
  input  logic                      data_we_i,
  input  logic [3:0]                data_be_i,
  input  logic [31:0]               data_wdata_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  output logic                      data_err_o,
  output logic [31:0]               data_rdata_o,
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [SW-1:0]             M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY,
  output logic [OW-1:0]             outstanding_o
);

  localparam int              CW       = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;
  localparam logic            THROTTLE = (POLL_GAP > 1);
  localparam logic [CW-1:0]   CD_LOAD  = THROTTLE ? CW'(POLL_GAP - 1) : {CW{1'b0}};
  localparam logic [OW-1:0]   MAX_OUT  = OW'(MAX_OUTSTANDING);

  logic                       slot_valid_q, slot_valid_d;
  logic                       slot_we_q, slot_we_d;
  logic [31:0]                slot_addr_q, slot_addr_d;
  logic [3:0]                 slot_be_q, slot_be_d;
  logic [31:0]                slot_wdata_q, slot_wdata_d;
  logic                       awvalid_q, awvalid_d;
  logic                       wvalid_q, wvalid_d;
  logic                       arvalid_q, arvalid_d;
  logic [OW-1:0]              out_cnt_q, out_cnt_d;
  logic                       out_we_q, out_we_d;
  logic [CW-1:0]              cooldown_q, cooldown_d;
  logic [MAX_OUTSTANDING-1:0] lane_q, lane_d;
  logic                       rvalid_q, rvalid_d;
  logic                       err_q, err_d;
  logic [31:0]                rdata_q, rdata_d;

  logic                       aw_hs_s, w_hs_s, ar_hs_s, b_hs_s, r_hs_s;
  logic                       resp_ready_s, issue_done_s, dir_ok_s, gnt_s;
  logic [OW-1:0]              lane_idx_s;
  logic [31:0]                rd_lane_s;
  logic                       unused_s;

  assign resp_ready_s = (out_cnt_q != {OW{1'b0}});
  assign aw_hs_s      = awvalid_q & M_AXI_AWREADY;
  assign w_hs_s       = wvalid_q & M_AXI_WREADY;
  assign ar_hs_s      = arvalid_q & M_AXI_ARREADY;
  assign b_hs_s       = M_AXI_BVALID & resp_ready_s;
  assign r_hs_s       = M_AXI_RVALID & resp_ready_s;

  // A write leaves the slot once each of AW and W has either already gone or goes now.
  assign issue_done_s = slot_valid_q & (slot_we_q ?
                        ((~awvalid_q | M_AXI_AWREADY) & (~wvalid_q | M_AXI_WREADY)) : ar_hs_s);

  // Only one direction may be in flight, which keeps B and R responses ordered.
  assign dir_ok_s = ~resp_ready_s | (out_we_q == data_we_i);
  assign gnt_s    = rst_n & data_req_i & ~slot_valid_q & (out_cnt_q < MAX_OUT) & dir_ok_s &
                    (data_we_i | (cooldown_q == {CW{1'b0}}));

  generate
    if (AXI_DATA_WIDTH == 64) begin : g_bus64
      assign M_AXI_WDATA = {slot_wdata_q, slot_wdata_q};
      assign M_AXI_WSTRB = slot_addr_q[2] ? {slot_be_q, 4'b0000} : {4'b0000, slot_be_q};
      assign rd_lane_s   = lane_q[0] ? M_AXI_RDATA[63:32] : M_AXI_RDATA[31:0];
    end else begin : g_bus32
      assign M_AXI_WDATA = slot_wdata_q;
      assign M_AXI_WSTRB = slot_be_q;
      assign rd_lane_s   = M_AXI_RDATA[31:0];
    end
  endgenerate

  // Issue slot and channel valids
  always_comb begin
    slot_we_d    = slot_we_q;
    slot_addr_d  = slot_addr_q;
    slot_be_d    = slot_be_q;
    slot_wdata_d = slot_wdata_q;
    if (gnt_s) begin
      slot_valid_d = 1'b1;
      slot_we_d    = data_we_i;
      slot_addr_d  = data_addr_i;
      slot_be_d    = data_be_i;
      slot_wdata_d = data_wdata_i;
      awvalid_d    = data_we_i;
      wvalid_d     = data_we_i;
      arvalid_d    = ~data_we_i;
    end else begin
      slot_valid_d = slot_valid_q & ~issue_done_s;
      awvalid_d    = awvalid_q & ~aw_hs_s;
      wvalid_d     = wvalid_q & ~w_hs_s;
      arvalid_d    = arvalid_q & ~ar_hs_s;
    end
  end

  // Outstanding count, direction tracking and read cooldown
  always_comb begin
    case ({issue_done_s, b_hs_s | r_hs_s})
      2'b10:   out_cnt_d = out_cnt_q + OW'(1);
      2'b01:   out_cnt_d = out_cnt_q - OW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
    out_we_d = issue_done_s ? slot_we_q : out_we_q;
    if (THROTTLE && gnt_s && !data_we_i) begin
      cooldown_d = CD_LOAD;
    end else if (cooldown_q != {CW{1'b0}}) begin
      cooldown_d = cooldown_q - CW'(1);
    end else begin
      cooldown_d = cooldown_q;
    end
  end

  // Lane FIFO: one entry per outstanding read, head at bit 0.
  assign lane_idx_s = out_cnt_q - (r_hs_s ? OW'(1) : OW'(0));

  always_comb begin
    lane_d = r_hs_s ? (lane_q >> 1'b1) : lane_q;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      lane_d[i] = (ar_hs_s && (OW'(i) == lane_idx_s)) ? slot_addr_q[2] : lane_d[i];
    end
  end

  // Response capture, presented one cycle after the B/R handshake
  always_comb begin
    rvalid_d = b_hs_s | r_hs_s;
    if (r_hs_s) begin
      err_d   = (M_AXI_RRESP != 2'b00);
      rdata_d = rd_lane_s;
    end else if (b_hs_s) begin
      err_d   = (M_AXI_BRESP != 2'b00);
      rdata_d = 32'h0000_0000;
    end else begin
      err_d   = 1'b0;
      rdata_d = 32'h0000_0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= 1'b0;
      slot_we_q    <= 1'b0;
      slot_addr_q  <= 32'h0000_0000;
      slot_be_q    <= 4'h0;
      slot_wdata_q <= 32'h0000_0000;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      out_cnt_q    <= {OW{1'b0}};
      out_we_q     <= 1'b0;
      cooldown_q   <= {CW{1'b0}};
      lane_q       <= {MAX_OUTSTANDING{1'b0}};
      rvalid_q     <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= 32'h0000_0000;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_we_q    <= slot_we_d;
      slot_addr_q  <= slot_addr_d;
      slot_be_q    <= slot_be_d;
      slot_wdata_q <= slot_wdata_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      out_cnt_q    <= out_cnt_d;
      out_we_q     <= out_we_d;
      cooldown_q   <= cooldown_d;
      lane_q       <= lane_d;
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign data_gnt_o    = gnt_s;
  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;
  assign data_rdata_o  = rdata_q;
  assign M_AXI_AWADDR  = {slot_addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign M_AXI_ARADDR  = {slot_addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_BREADY  = resp_ready_s;
  assign M_AXI_RREADY  = resp_ready_s;
  assign outstanding_o = out_cnt_q;
  assign unused_s      = ^{slot_addr_q, lane_q};

endmodule

// File: tb/tb_dev_to_maxil_pipe.sv
// Directed bench: a 32-bit and a 64-bit bridge share all stimulus; the 64-bit one
// is checked for lane steering, the 32-bit one for everything else.
`timescale 1ns/1ps
module tb_dev_to_maxil_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req, we, awready, wready, bvalid, arready, rvalid;
  logic [31:0] addr, wdata, rd_lo, rd_hi;
  logic [3:0]  be;
  logic [1:0]  bresp, rresp;

  logic        gnt, rv, err, awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] rdata, awaddr, araddr, wdata32;
  logic [3:0]  wstrb;
  logic [2:0]  outst;

  logic        gnt64, rv64, err64, awvalid64, wvalid64, bready64, arvalid64, rready64;
  logic [31:0] rdata64, awaddr64, araddr64;
  logic [63:0] wdata64;
  logic [7:0]  wstrb64;
  logic [2:0]  outst64;

  dev_to_maxil_pipe #(.ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .MAX_OUTSTANDING(4), .POLL_GAP(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .data_req_i(req), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt), .data_rvalid_o(rv),
    .data_err_o(err), .data_rdata_o(rdata),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata32), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rd_lo), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .outstanding_o(outst)
  );

  dev_to_maxil_pipe #(.ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .MAX_OUTSTANDING(4), .POLL_GAP(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .data_req_i(req), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt64), .data_rvalid_o(rv64),
    .data_err_o(err64), .data_rdata_o(rdata64),
    .M_AXI_AWADDR(awaddr64), .M_AXI_AWVALID(awvalid64), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata64), .M_AXI_WSTRB(wstrb64), .M_AXI_WVALID(wvalid64), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready64),
    .M_AXI_ARADDR(araddr64), .M_AXI_ARVALID(arvalid64), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA({rd_hi, rd_lo}), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready64),
    .outstanding_o(outst64)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants, bbeats, pulses, rb, first_rv, g5, wg, nrv;
    logic [5:0] errv;
    logic seen;
    int gc[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp64_q[$];
    logic [31:0] got[$];

    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rd_lo = 32'h0; rd_hi = 32'h0;
    step(); step();
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b00000);
    chk("rst_rsp", {gnt, rv, err}, 3'b000);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_out", outst, 3'd0);
    rst_n = 1'b1;
    step();

    // single write, zero-wait slave
    awready = 1'b1; wready = 1'b1;
    req = 1'b1; we = 1'b1; addr = 32'h1004; be = 4'hF; wdata = 32'hDEADBEEF;
    #1 chk("t1_gnt", gnt, 1'b1);
    step(); req = 1'b0;
    #1 chk("t1_valids", {awvalid, wvalid}, 2'b11);
    chk("t1_awaddr", awaddr, 32'h1004);
    chk("t1_wdata", wdata32, 32'hDEADBEEF);
    chk("t1_wdata64", wdata64, 64'hDEADBEEF_DEADBEEF);
    chk("t1_wstrb64", wstrb64, 8'hF0);
    step();
    chk("t1_issued", {awvalid, wvalid, outst}, {1'b0, 1'b0, 3'd1});
    bvalid = 1'b1; bresp = 2'b00;
    step(); bvalid = 1'b0;
    #1 chk("t1_rsp", {rv, err, outst}, {1'b1, 1'b0, 3'd0});
    step();
    chk("t1_pulse_end", rv, 1'b0);

    // AW held off three cycles, W immediate
    awready = 1'b0; wready = 1'b1;
    req = 1'b1; we = 1'b1; addr = 32'h2008; wdata = 32'h12345678;
    #1 chk("t2_gnt", gnt, 1'b1);
    step(); req = 1'b0;
    #1 chk("t2_valids", {awvalid, wvalid}, 2'b11);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_aw_hold", {awvalid, wvalid, outst}, {1'b1, 1'b0, 3'd0});
    end
    awready = 1'b1;
    step();
    chk("t2_aw_done", {awvalid, outst}, {1'b0, 3'd1});
    bvalid = 1'b1;
    step(); bvalid = 1'b0;
    #1 chk("t2_rsp", rv, 1'b1);
    step();

    // outstanding limit, then six B responses with an error on the third
    grants = 0; bbeats = 0; pulses = 0; errv = 6'b0;
    for (int c = 0; c < 70; c++) begin
      req = (grants < 6); we = 1'b1; addr = 32'h3000;
      bvalid = (c >= 14) && (bbeats < 6);
      bresp = (bbeats == 2) ? 2'b10 : 2'b00;
      #1;
      if (c == 14) begin
        chk("t3_out_full", outst, 3'd4);
        chk("t3_gnt_blocked", gnt, 1'b0);
      end
      if (gnt && req) grants++;
      if (bvalid && bready) begin
        if (bbeats == 0) chk("t3_grants_pre_b", grants, 4);
        bbeats++;
      end
      if (rv) begin
        if (pulses < 6) errv[pulses] = err;
        pulses++;
      end
      step();
    end
    bvalid = 1'b0; bresp = 2'b00; req = 1'b0;
    chk("t3_grants", grants, 6);
    chk("t3_pulses", pulses, 6);
    chk("t3_err_pattern", errv, 6'b000100);
    chk("t3_out_end", outst, 3'd0);

    // read throttle with a zero-wait slave
    arready = 1'b1; rvalid = 1'b1; rresp = 2'b00; rb = 0; first_rv = -1;
    for (int c = 0; c < 44; c++) begin
      req = (c < 34); we = 1'b0; addr = 32'h4000;
      rd_lo = 32'hA000_0000 + 32'(rb); rd_hi = 32'h5555_0000 + 32'(rb);
      #1;
      if (gnt && req) gc.push_back(c);
      if (rvalid && rready) begin
        exp_q.push_back(rd_lo);
        exp64_q.push_back(rd_lo);
        rb++;
      end
      if (rv) begin
        if (first_rv < 0) first_rv = c;
        if (exp_q.size() == 0) chk("t4_spurious_rvalid", 1'b1, 1'b0);
        else begin
          chk("t4_rdata", rdata, exp_q.pop_front());
          chk("t4_rdata64", rdata64, exp64_q.pop_front());
        end
      end
      step();
    end
    req = 1'b0;
    chk("t4_ngrants", gc.size(), 5);
    if (gc.size() > 0) chk("t4_first_gnt", gc[0], 0);
    for (int i = 1; i < gc.size(); i++) chk("t4_gap", gc[i] - gc[i-1], 8);
    chk("t4_latency", first_rv, 3);
    chk("t4_beats", rb, 5);

    // 64-bit lane selection
    rd_hi = 32'h1111_2222; rd_lo = 32'h3333_4444; g5 = 0; seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      req = (g5 < 2); we = 1'b0; addr = (g5 == 0) ? 32'h2004 : 32'h2000;
      #1;
      if (arvalid64 && !seen) begin
        chk("t5_araddr", araddr64, 32'h2004);
        seen = 1'b1;
      end
      if (gnt64 && req) g5++;
      if (rv64) got.push_back(rdata64);
      step();
    end
    req = 1'b0; rvalid = 1'b0;
    chk("t5_nrsp", got.size(), 2);
    if (got.size() == 2) begin
      chk("t5_upper_lane", got[0], 32'h1111_2222);
      chk("t5_lower_lane", got[1], 32'h3333_4444);
    end
    req = 1'b1; we = 1'b1; addr = 32'h2004; be = 4'h3; wdata = 32'hCAFEF00D;
    #1 chk("t5_wgnt", gnt64, 1'b1);
    step(); req = 1'b0;
    #1 chk("t5_wstrb64", wstrb64, 8'h30);
    chk("t5_wstrb32", wstrb, 4'h3);
    chk("t5_wdata64", wdata64, 64'hCAFEF00D_CAFEF00D);
    chk("t5_awaddr64", awaddr64, 32'h2004);
    step(); bvalid = 1'b1;
    step(); bvalid = 1'b0;
    step();

    // direction rule, then reset with two writes outstanding
    req = 1'b1; we = 1'b0; addr = 32'h5000;
    #1 chk("t6_rgnt", gnt, 1'b1);
    step();
    we = 1'b1; addr = 32'h5008; be = 4'hF; wdata = 32'h0000_0001; wg = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (gnt) wg++;
      step();
    end
    chk("t6_dir_block", wg, 0);
    rvalid = 1'b1; rd_lo = 32'h0000_0077;
    #1 chk("t6_gnt_before_r", gnt, 1'b0);
    step(); rvalid = 1'b0;
    #1 chk("t6_gnt_at_rvalid", {rv, gnt}, 2'b11);
    chk("t6_read_data", rdata, 32'h0000_0077);
    wg = 0;
    for (int k = 0; k < 6; k++) begin
      req = (wg < 2);
      #1;
      if (gnt && req) wg++;
      step();
    end
    chk("t6_two_out", outst, 3'd2);
    bvalid = 1'b1; rst_n = 1'b0; req = 1'b1;
    #1 chk("t6_rst_valids", {awvalid, wvalid, arvalid, bready, rready, rv, err, gnt}, 8'h00);
    chk("t6_rst_rdata", rdata, 32'h0);
    chk("t6_rst_out", outst, 3'd0);
    step(); rst_n = 1'b1; req = 1'b0; nrv = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (rv) nrv++;
      step();
    end
    bvalid = 1'b0;
    chk("t6_no_rvalid", nrv, 0);
    chk("t6_out_after", outst, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dev_to_maxil_pipe.md
Name: dev_to_maxil_pipe

Overview:
- Pipelined successor to the single-outstanding Ibex-to-AXI-Lite bridge.
- Accepts Ibex-style device-port requests and issues them as AXI-Lite master transactions. Up to MAX_OUTSTANDING transactions may be in flight, AW and W are issued concurrently, and all responses return in order.
- Supports a 32- or 64-bit AXI data bus via lane steering, plus a configurable read-poll throttle.
- Sits between the core data port and the AXI-Lite control interconnect.

Parameters:
- ADDR_WIDTH, 32, AXI address width (≤32).
- AXI_DATA_WIDTH, 32, AXI data width; legal values 32 or 64.
- MAX_OUTSTANDING, 4, max issued-but-unresponded transactions; ≥1.
- POLL_GAP, 8, minimum cycles between read grants; 0 or 1 disables the throttle.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_req_i  in  1  device request
- data_addr_i  in  32  byte address
- data_we_i  in  1  1=write
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  request accepted this cycle
- data_rvalid_o  out  1  response pulse
- data_err_o  out  1  response error, valid with rvalid
- data_rdata_o  out  32  read data, valid with rvalid
- M_AXI_AW*/W*/B*/AR*/R*  per AXI-Lite  ADDR_WIDTH / AXI_DATA_WIDTH / AXI_DATA_WIDTH/8 / 2  standard AXI-Lite master channels (AWADDR, AWVALID, AWREADY, WDATA, WSTRB, WVALID, WREADY, BRESP, BVALID, BREADY, ARADDR, ARVALID, ARREADY, RDATA, RRESP, RVALID, RREADY)
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  transactions in flight, status only

Behaviour:
- Reset: all VALID/READY outputs 0, data_gnt_o 0, rvalid 0, err 0, rdata 0, outstanding 0, issue slot empty, cooldown 0.
- Reset asserted mid-transaction: all in-flight transactions are dropped and no rvalid is produced for them.
- Issue slot: single entry holding one granted request.
- Grant condition: data_gnt_o=1 (combinational) when all of the following hold:
  - data_req_i=1;
  - issue slot empty;
  - outstanding_o < MAX_OUTSTANDING;
  - direction rule passes;
  - for reads, cooldown==0.
- Granted request is latched into the slot at that clock edge.
- Direction rule: a read is granted only if no writes are outstanding or in the slot, and vice versa. Reads and writes are never in flight together, which guarantees in-order responses.
- Write issue:
  - AWVALID and WVALID assert together the cycle after grant.
  - Each deasserts independently after its own handshake.
  - The slot frees when both AW and W have completed; outstanding increments that cycle.
- Read issue: ARVALID asserts the cycle after grant; on AR handshake the slot frees and outstanding increments.
- Addresses: AWADDR/ARADDR = {addr[ADDR_WIDTH-1:2], 2'b00}.
- 64-bit lane steering:
  - WDATA = {wdata, wdata}; WSTRB = be<<4 when addr[2]=1, otherwise be in the low 4 bits.
  - addr[2] is pushed into a lane FIFO (depth MAX_OUTSTANDING) at AR issue; read data = RDATA[63:32] if the popped lane bit=1, else RDATA[31:0].
- 32-bit bus: no steering.
- BREADY = RREADY = (outstanding_o != 0). B/R beats arriving with nothing outstanding are not accepted.
- Responses:
  - On a B or R handshake, the response registers capture err = (RESP != 2'b00) and rdata (reads; writes give 0).
  - rvalid pulses exactly 1 cycle later.
  - Back-to-back handshakes give back-to-back rvalid pulses.
  - Outstanding decrements on a B/R handshake; simultaneous increment and decrement leaves it unchanged.
- Throttle: on a read grant with POLL_GAP>1, cooldown loads POLL_GAP-1 and then decrements by 1 per cycle to 0. Writes are never throttled.
- Minimum read latency, grant → rvalid, with zero-wait slave: grant cycle, AR handshake next cycle, R handshake the cycle after, rvalid one cycle later (3 cycles).

Test Plan:
- Single write, 32-bit bus: addr 0x1004, be 0xF, wdata 0xDEADBEEF, AWREADY=WREADY=1, BVALID 1 cycle after → AWADDR=0x1004 and WDATA=0xDEADBEEF in the same cycle; one rvalid with err=0.
- AW/W skew: AWREADY delayed 3 cycles, WREADY immediate → WVALID drops after 1 cycle, AWVALID held 4 cycles; outstanding goes to 1 only after the AW handshake.
- Outstanding limit: MAX_OUTSTANDING=4, 6 back-to-back writes, BVALID held off → 4 grants, then gnt=0 until the first B; after the B responses, 6 rvalid pulses in order; BRESP=2'b10 on the 3rd → err=1 on the 3rd pulse only.
- Read throttle: POLL_GAP=8, data_req_i held with reads → successive grants exactly 8 cycles apart; rdata equals RDATA per beat.
- 64-bit lanes: AXI_DATA_WIDTH=64, read 0x2004 then 0x2000, RDATA=0x11112222_33334444 both times → rdata 0x11112222 then 0x33334444; write to 0x2004 with be 0x3 → WSTRB=0x30.
- Direction / reset: read in flight with a write requested → no write grant until the read's rvalid. Then rst_n pulsed low with 2 transactions outstanding → all outputs 0, no rvalid after release, outstanding_o=0.
